pixel_pair_loader: RTL and testbench
====================================

# pixel_pair_loader

Input stage that sits directly upstream of the image processor core. It accepts a serial pixel stream over a valid/ready handshake and packs consecutive pixels into (pixelA, pixelB) pairs. It buffers the pairs in a small FIFO and presents each one, together with the latched opcode and user input, to the parallel cell processors. Odd-length frames are padded so that every frame ends on a complete pair.

## Interface
Parameters:
- PIXEL_W, 8, width of one pixel (matches pixel_t)
- OPCODE_W, 4, opcode width (matches opCodeWidth)
- DEPTH, 4, FIFO depth in pairs; power of two, at least 2

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  loader can accept a pixel
- in_pixel  in  PIXEL_W  incoming pixel
- in_last  in  1  marks the last pixel of a frame
- cfg_load  in  1  one-cycle strobe to latch cfg_opcode and cfg_user
- cfg_opcode  in  OPCODE_W  operation for the next frame
- cfg_user  in  PIXEL_W  user operand for the next frame
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected
- out_valid  out  1  pair available to the core
- out_ready  in  1  core consumes the pair
- out_pixelA  out  PIXEL_W  first pixel of the pair
- out_pixelB  out  PIXEL_W  second pixel of the pair (0 when padded)
- out_last  out  1  pair closes the frame
- out_opcode  out  OPCODE_W  latched opcode
- out_userInput  out  PIXEL_W  latched user operand
- busy  out  1  frame in progress or FIFO non-empty

## Operation
- Input acceptance: a pixel is accepted when in_valid && in_ready.
- in_ready = (count != DEPTH). It is registered-state only and never depends on in_valid or out_ready.
- Pairing FSM, IDLE state (no half pair held):
  - Accepted pixel with in_last=0: store it in holdA, go to HALF.
  - Accepted pixel with in_last=1: push {pixel, 0, last=1}, stay in IDLE.
- Pairing FSM, HALF state (holdA valid):
  - Accepted pixel: push {holdA, pixel, last=in_last}, go to IDLE.
- FIFO: circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally) and count (log2 DEPTH + 1 bits).
  - Push and pop in the same cycle leave count unchanged and are always legal.
  - Full is reached only by a push with no pop; the FIFO can never overflow because in_ready gates pushes.
- Output (first-word-fall-through):
  - out_valid = (count != 0). The out_pixel*/out_last fields are the head entry.
  - A pop occurs on out_valid && out_ready.
  - out_opcode and out_userInput come directly from the config registers.
- Configuration:
  - cfg_load is accepted only when busy=0; it updates both config registers on the next edge.
  - cfg_load while busy=1 is ignored, the registers are unchanged, and cfg_err pulses on the next cycle.
- busy = (state == HALF) || (count != 0).
- Output data holds while out_valid=1 && out_ready=0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_pixelA=0, out_pixelB=0, out_last=0.
  - out_opcode=0, out_userInput=0, cfg_err=0, busy=0.
  - FSM in IDLE; pointers and count at 0.
- Reset mid-frame drops holdA and all FIFO contents immediately; nothing partial is emitted afterwards.
- Latency: second pixel of a pair accepted at edge N gives out_valid=1 in the cycle after edge N.
- Odd-frame pad: a last pixel accepted in IDLE gives out_valid the cycle after its accepting edge.
- Sustained throughput: one pixel per cycle in, one pair per two cycles out, with no bubbles when out_ready=1.
- Full: in_ready=0 while count=DEPTH. A pop at full raises in_ready in the following cycle (no same-cycle bypass).
- In HALF with the FIFO full, the pixel still waits, because in_ready is low.
- cfg_load and the first pixel of a new frame in the same cycle (busy=0): the config is accepted; the pixel is accepted if in_ready=1.

## Structure
- ImageProcessingPkg:
  - pixel_t and PIXEL_WIDTH.
  - New pixelPair_t packed struct {pixel_t a; pixel_t b; logic last}.
- CellProcessingPkg: opCodeWidth and opcode_t, reused for out_opcode.
- One sub-module, pair_fifo: parameterized on DEPTH and the pixelPair_t payload. It provides push/pop/full/empty/count and first-word-fall-through read.
- The pairing FSM and config registers live in pixel_pair_loader.

## Test plan
- Even frame: after reset, stream 10,20,30,40 (last on 40) with out_ready=1.
  - Required: pairs (10,20,last0) then (30,40,last1).
  - Required: out_valid rises the cycle after 20 is accepted.
- Odd frame: stream 5,6,7 (last on 7).
  - Required: pairs (5,6,0) then (7,0,1).
  - Required: busy falls after the second pop.
- Backpressure: hold out_ready=0 with DEPTH=4 and stream 8 pixels.
  - Required: in_ready falls after the 8th pixel and count=4.
  - Required: releasing out_ready drains the 4 pairs in order, and in_ready returns one cycle after the first pop.
- Config gating: cfg_load opcode=3, user=0x80 while idle, then cfg_load opcode=5 mid-frame.
  - Required: out_opcode=3 and out_userInput=0x80 throughout.
  - Required: cfg_err pulses once.
- Reset mid-frame: accept pixel 9 (state HALF) and two full pairs, then assert rst one cycle.
  - Required: out_valid=0, busy=0, in_ready=1.
  - Required: the next frame 1,2 yields only (1,2,1).

Source files
------------

// File: rtl/pixel_pair_loader_pkg.sv
// Shared types for the pixel pair loader: pixel/opcode types, the packed pair
// payload carried through the FIFO, and the pairing FSM state encoding.
package pixel_pair_loader_pkg;

  localparam int PIXEL_WIDTH = 8;
  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  localparam int opCodeWidth = 4;
  typedef logic [opCodeWidth-1:0] opcode_t;

  typedef struct packed {
    pixel_t a;
    pixel_t b;
    logic   last;
  } pixelPair_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } pair_state_e;

endpackage

// File: rtl/pair_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head. Payload storage is
// not reset; only pointers and occupancy are.
module pair_fifo
  import pixel_pair_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(pixelPair_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_pair_loader.sv
// Packs a serial pixel stream into (A,B) pairs, padding odd frames, buffers the
// pairs in pair_fifo and presents them with the frame's latched configuration.
module pixel_pair_loader
  import pixel_pair_loader_pkg::*;
#(
  parameter int PIXEL_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIXEL_W-1:0]  in_pixel,
  input  logic                in_last,
  input  logic                cfg_load,
  input  logic [OPCODE_W-1:0] cfg_opcode,
  input  logic [PIXEL_W-1:0]  cfg_user,
  output logic                cfg_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PIXEL_W-1:0]  out_pixelA,
  output logic [PIXEL_W-1:0]  out_pixelB,
  output logic                out_last,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [PIXEL_W-1:0]  out_userInput,
  output logic                busy
);

  localparam int PW = 2 * PIXEL_W + 1;

  pair_state_e             r_state;
  pair_state_e             w_state_nxt;
  logic [PIXEL_W-1:0]      r_holdA;
  logic [OPCODE_W-1:0]     r_opcode;
  logic [PIXEL_W-1:0]      r_user;
  logic                    r_cfg_err;

  logic                    w_accept;
  logic                    w_load_hold;
  logic                    w_push;
  logic [PW-1:0]           w_push_data;
  logic                    w_pop;
  logic [PW-1:0]           w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;

  assign in_ready  = !w_full;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign busy      = (r_state == ST_HALF) || (w_count != '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_hold = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_last) begin
            // Lone last pixel closes the frame with a zero pad in slot B.
            w_push      = 1'b1;
            w_push_data = {in_pixel, {PIXEL_W{1'b0}}, 1'b1};
          end else begin
            w_load_hold = 1'b1;
            w_state_nxt = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (w_accept) begin
          w_push      = 1'b1;
          w_push_data = {r_holdA, in_pixel, in_last};
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_hold) r_holdA <= in_pixel;
  end

  // Config only changes between frames; a late load is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode  <= '0;
      r_user    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load && busy;
      if (cfg_load && !busy) begin
        r_opcode <= cfg_opcode;
        r_user   <= cfg_user;
      end
    end
  end

  pair_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Head fields are masked while empty so stale storage never shows.
  assign out_pixelA    = out_valid ? w_head[PW-1 -: PIXEL_W] : '0;
  assign out_pixelB    = out_valid ? w_head[PIXEL_W -: PIXEL_W] : '0;
  assign out_last      = out_valid ? w_head[0] : 1'b0;
  assign out_opcode    = r_opcode;
  assign out_userInput = r_user;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_pixel_pair_loader.sv
// Directed plus random bench for pixel_pair_loader against a queue-based model
// of frame pairing, FIFO occupancy and config gating.
module tb_pixel_pair_loader;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       in_last;
  logic       cfg_load;
  logic [3:0] cfg_opcode;
  logic [7:0] cfg_user;
  logic       cfg_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixelA;
  logic [7:0] out_pixelB;
  logic       out_last;
  logic [3:0] out_opcode;
  logic [7:0] out_userInput;
  logic       busy;

  pixel_pair_loader #(.PIXEL_W(8), .OPCODE_W(4), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pixel      (in_pixel),
    .in_last       (in_last),
    .cfg_load      (cfg_load),
    .cfg_opcode    (cfg_opcode),
    .cfg_user      (cfg_user),
    .cfg_err       (cfg_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixelA    (out_pixelA),
    .out_pixelB    (out_pixelB),
    .out_last      (out_last),
    .out_opcode    (out_opcode),
    .out_userInput (out_userInput),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  int    n_checks = 0;
  int    n_err    = 0;

  // Reference model: pairs awaiting delivery, half-pair holding, latched config.
  pair_t exp_q[$];
  int    occ;
  bit    half;
  logic [7:0] half_px;
  logic [3:0] m_op;
  logic [7:0] m_us;
  bit    m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    occ   = 0;
    half  = 0;
    m_op  = '0;
    m_us  = '0;
    m_err = 0;
  endtask

  task automatic tick(input logic v, input logic [7:0] px, input logic l, input logic ordy,
                      input logic cl, input logic [3:0] op, input logic [7:0] us);
    bit    pop, acc, mbusy;
    pair_t p;
    in_valid   = v;
    in_pixel   = px;
    in_last    = l;
    out_ready  = ordy;
    cfg_load   = cl;
    cfg_opcode = op;
    cfg_user   = us;
    @(negedge clk);
    mbusy = half || (occ != 0);
    chk("in_ready",  in_ready,  occ != DEPTH);
    chk("out_valid", out_valid, occ != 0);
    chk("busy",      busy,      mbusy);
    chk("cfg_err",   cfg_err,   m_err);
    chk("opcode",    out_opcode, m_op);
    chk("user",      out_userInput, m_us);
    if (occ != 0) begin
      chk("pixelA", out_pixelA, exp_q[0].a);
      chk("pixelB", out_pixelB, exp_q[0].b);
      chk("last",   out_last,   exp_q[0].last);
    end
    pop   = ordy && (occ != 0);
    acc   = v && (occ != DEPTH);
    m_err = cl && mbusy;
    if (cl && !mbusy) begin
      m_op = op;
      m_us = us;
    end
    if (pop) begin
      void'(exp_q.pop_front());
      occ--;
    end
    if (acc) begin
      if (half) begin
        p = '{half_px, px, l};
        exp_q.push_back(p);
        occ++;
        half = 0;
      end else if (l) begin
        p = '{px, 8'h00, 1'b1};
        exp_q.push_back(p);
        occ++;
      end else begin
        half    = 1;
        half_px = px;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] px, input logic l, input logic ordy);
    tick(1'b1, px, l, ordy, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 8'h00, 1'b0, ordy, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_pixelA",    out_pixelA, 8'h00);
    chk("rst_pixelB",    out_pixelB, 8'h00);
    chk("rst_last",      out_last,  1'b0);
    chk("rst_cfg_err",   cfg_err,   1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_pixel = 0; in_last = 0; out_ready = 0;
    cfg_load = 0; cfg_opcode = 0; cfg_user = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_opcode", out_opcode, 4'h0);
    chk("rst_user",   out_userInput, 8'h00);

    // Even frame
    pix(8'd10, 0, 1); pix(8'd20, 0, 1); pix(8'd30, 0, 1); pix(8'd40, 1, 1);
    repeat (3) idle(1);

    // Odd frame
    pix(8'd5, 0, 1); pix(8'd6, 0, 1); pix(8'd7, 1, 1);
    repeat (3) idle(1);

    // Backpressure: fill to DEPTH, hold, then drain
    for (int i = 1; i <= 8; i++) pix(8'(i + 100), i == 8, 0);
    repeat (2) idle(0);
    pix(8'd200, 0, 1);
    pix(8'd201, 1, 1);
    repeat (6) idle(1);

    // Config gating
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd3, 8'h80);
    pix(8'd50, 0, 1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5, 8'h11);
    pix(8'd51, 1, 1);
    repeat (3) idle(1);
    // Config and first pixel of a new frame together
    tick(1'b1, 8'd60, 1'b0, 1'b1, 1'b1, 4'd9, 8'h42);
    pix(8'd61, 1, 1);
    repeat (3) idle(1);

    // Reset mid-frame: two full pairs plus a held pixel
    pix(8'd70, 0, 0); pix(8'd71, 0, 0); pix(8'd72, 0, 0); pix(8'd73, 0, 0);
    pix(8'd9, 0, 0);
    do_reset();
    pix(8'd1, 0, 1); pix(8'd2, 1, 1);
    repeat (3) idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0),
           4'($urandom), 8'($urandom));
    end
    repeat (12) idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
